serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle for the bit-serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin, sub,
    input  sum, cout, overflow, busy, done
  );

  modport slave (
    input  start, a, b, cin, sub,
    output sum, cout, overflow, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/sub, one full-adder cell reused LSB-first over WIDTH cycles
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] s_vec;

  // The single full-adder cell; operands are always consumed from bit 0.
  always_comb begin
    bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    bit_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    s_vec = '0;
    s_vec[WIDTH-1] = bit_s;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        carry_d = bit_c;
        acc_d   = (acc_q >> 1) | s_vec;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB, so it pairs with bit_c for signed overflow.
          sum_d   = (acc_q >> 1) | s_vec;
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder at WIDTH 1, 8 and 32
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(if1));
  serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));

  // Reference: plain integer arithmetic, overflow from operand/result signs.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, am, bm, tot, s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, a} & mask;
    bm   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    tot  = am + bm + {63'd0, (sub ? 1'b1 : cin)};
    s    = tot & mask;
    co   = tot[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s[31:0]};
  endfunction

  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic start);
    case (w)
      1: begin if1.a = a[0];    if1.b = b[0];    if1.cin = cin; if1.sub = sub; if1.start = start; end
      8: begin if8.a = a[7:0];  if8.b = b[7:0];  if8.cin = cin; if8.sub = sub; if8.start = start; end
      default: begin if32.a = a; if32.b = b; if32.cin = cin; if32.sub = sub; if32.start = start; end
    endcase
  endtask

  task automatic obs(input int w, output bit d, output bit bz, output logic [31:0] sum,
                     output logic cout, output logic ovf);
    case (w)
      1: begin d = if1.done; bz = if1.busy; sum = {31'd0, if1.sum}; cout = if1.cout; ovf = if1.overflow; end
      8: begin d = if8.done; bz = if8.busy; sum = {24'd0, if8.sum}; cout = if8.cout; ovf = if8.overflow; end
      default: begin d = if32.done; bz = if32.busy; sum = if32.sum; cout = if32.cout; ovf = if32.overflow; end
    endcase
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that leaves DONE.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output logic [31:0] sum, output logic cout,
                        output logic ovf, output int lat, output int busy_n, output bit both);
    bit d, bz, got;
    got = 0; lat = -1; busy_n = 0; both = 0;
    sum = 'x; cout = 1'bx; ovf = 1'bx;
    drive(w, a, b, cin, sub, 1'b1);
    @(posedge clk); #1;
    drive(w, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
    for (int n = 1; n < 80 && !got; n++) begin
      obs(w, d, bz, sum, cout, ovf);
      if (bz) busy_n++;
      if (bz && d) both = 1;
      if (d) begin
        got = 1;
        lat = n;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] prev8, prev32;
  bit          rst_hist = 1;
  always @(negedge clk) begin
    if (!rst_hist) begin
      n_checks += 2;
      if (!if8.done && {24'd0, if8.sum} !== prev8) begin
        n_fail++;
        $display("FAIL sum_stable_w8: sum=%h changed from %h outside done", if8.sum, prev8);
      end
      if (!if32.done && if32.sum !== prev32) begin
        n_fail++;
        $display("FAIL sum_stable_w32: sum=%h changed from %h outside done", if32.sum, prev32);
      end
    end
    prev8    = {24'd0, if8.sum};
    prev32   = if32.sum;
    rst_hist = rst;
  end

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0, 0);
    drive(32, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({if8.sum, if8.cout, if8.overflow, if8.busy, if8.done} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_w8: outputs=%h required 0", {if8.sum, if8.cout, if8.overflow, if8.busy, if8.done});
    end
    n_checks++;
    if ({if32.sum, if32.cout, if32.overflow, if32.busy, if32.done} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_w32: outputs=%h required 0", {if32.sum, if32.cout, if32.overflow, if32.busy, if32.done});
    end
    n_checks++;
    if ({if1.sum, if1.cout, if1.overflow, if1.busy, if1.done} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_w1: outputs=%h required 0", {if1.sum, if1.cout, if1.overflow, if1.busy, if1.done});
    end
  endtask

  task automatic test_vectors_w8();
    logic [31:0] va [4] = '{32'h5A, 32'hFF, 32'h10, 32'h80};
    logic [31:0] vb [4] = '{32'h3C, 32'h01, 32'h20, 32'h01};
    logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0]  ve [4] = '{{1'b1, 1'b0, 8'h96}, {1'b0, 1'b1, 8'h01}, {1'b0, 1'b0, 8'hF0}, {1'b1, 1'b1, 8'h7F}};
    logic [31:0] sum;
    logic        cout, ovf;
    int          lat, busy_n;
    bit          both;
    logic [33:0] m;
    for (int i = 0; i < 4; i++) begin
      run_op(8, va[i], vb[i], vc[i], vs[i], sum, cout, ovf, lat, busy_n, both);
      m = model(8, va[i], vb[i], vc[i], vs[i]);
      n_checks++;
      if ({ovf, cout, sum[7:0]} !== ve[i] || {ovf, cout, sum[7:0]} !== {m[33:32], m[7:0]}) begin
        n_fail++;
        $display("FAIL vec%0d_result: {ovf,cout,sum}=%h required %h", i, {ovf, cout, sum[7:0]}, ve[i]);
      end
      n_checks++;
      if (lat != 9 || busy_n != 8 || both) begin
        n_fail++;
        $display("FAIL vec%0d_timing: lat=%0d busy=%0d both=%0d required 9 8 0", i, lat, busy_n, both);
      end
    end
  endtask

  task automatic test_back_to_back();
    int  last, ndone, extra;
    bit  seen;
    last = -1; ndone = 0; extra = 0; seen = 0;
    drive(8, 32'h80, 32'h01, 1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        ndone++;
        n_checks++;
        if ({if8.overflow, if8.cout, if8.sum} !== 10'h37F) begin
          n_fail++;
          $display("FAIL b2b_result: {ovf,cout,sum}=%h required 37f", {if8.overflow, if8.cout, if8.sum});
        end
        if (last >= 0) begin
          n_checks++;
          if (e - last != 10) begin
            n_fail++;
            $display("FAIL b2b_spacing: spacing=%0d required 10", e - last);
          end
        end
        last = e;
      end
    end
    if8.start = 1'b0;
    n_checks++;
    if (ndone != 4) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d required 4", ndone);
    end
    repeat (14) @(posedge clk);
    #1;
    drive(8, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int e = 0; e < 20 && !seen; e++) begin
      if (if8.done) begin
        seen = 1;
        if8.start = 1'b1;
        n_checks++;
        if (if8.sum !== 8'h33) begin
          n_fail++;
          $display("FAIL ignore_start_result: sum=%h required 33", if8.sum);
        end
      end else begin
        if8.start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    if8.start = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (if8.done) extra++;
    end
    n_checks++;
    if (!seen || extra != 0) begin
      n_fail++;
      $display("FAIL ignore_start: seen=%0d extra_dones=%0d required 1 0", seen, extra);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] sum;
    logic        cout, ovf;
    int          lat, busy_n, extra;
    bit          both;
    extra = 0;
    drive(8, 32'hC3, 32'h5A, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({if8.sum, if8.cout, if8.overflow, if8.busy, if8.done} !== 12'd0) begin
      n_fail++;
      $display("FAIL abort_reset: outputs=%h required 0", {if8.sum, if8.cout, if8.overflow, if8.busy, if8.done});
    end
    repeat (12) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL abort_no_report: active_cycles=%0d required 0", extra);
    end
    run_op(8, 32'hC3, 32'h5A, 1'b1, 1'b0, sum, cout, ovf, lat, busy_n, both);
    n_checks++;
    if ({ovf, cout, sum[7:0]} !== 10'h11E || lat != 9) begin
      n_fail++;
      $display("FAIL after_abort: {ovf,cout,sum}=%h lat=%0d required 11e 9", {ovf, cout, sum[7:0]}, lat);
    end
  endtask

  task automatic test_width1();
    logic [31:0] sum;
    logic        cout, ovf;
    int          lat, busy_n;
    bit          both;
    logic [33:0] m;
    int          tot;
    for (int i = 0; i < 8; i++) begin
      run_op(1, 32'(i >> 2), 32'((i >> 1) & 1), 1'(i & 1), 1'b0, sum, cout, ovf, lat, busy_n, both);
      tot = (i >> 2) + ((i >> 1) & 1) + (i & 1);
      m = model(1, 32'(i >> 2), 32'((i >> 1) & 1), 1'(i & 1), 1'b0);
      n_checks++;
      if ({cout, sum[0]} !== 2'(tot) || ovf !== m[33]) begin
        n_fail++;
        $display("FAIL w1_fa%0d: cout,sum=%b%b ovf=%b required %b ovf=%b", i, cout, sum[0], ovf, 2'(tot), m[33]);
      end
      n_checks++;
      if (lat != 2 || busy_n != 1 || both) begin
        n_fail++;
        $display("FAIL w1_timing%0d: lat=%0d busy=%0d required 2 1", i, lat, busy_n);
      end
    end
  endtask

  task automatic test_random_w32();
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, ovf;
    int          lat, busy_n;
    bit          both;
    logic [33:0] m;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom;
      cin = 1'($urandom); sub = 1'($urandom);
      if (i < 4) begin
        a = (i < 2) ? 32'h7FFF_FFFF : 32'h8000_0000;
        b = (i[0]) ? 32'hFFFF_FFFF : 32'h0000_0001;
      end
      run_op(32, a, b, cin, sub, sum, cout, ovf, lat, busy_n, both);
      m = model(32, a, b, cin, sub);
      n_checks++;
      if ({ovf, cout, sum} !== m) begin
        n_fail++;
        $display("FAIL w32_rand%0d: a=%h b=%h cin=%b sub=%b got %h required %h", i, a, b, cin, sub, {ovf, cout, sum}, m);
      end
      n_checks++;
      if (lat != 33 || busy_n != 32 || both) begin
        n_fail++;
        $display("FAIL w32_timing%0d: lat=%0d busy=%0d both=%0d required 33 32 0", i, lat, busy_n, both);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors_w8();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    test_random_w32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
